// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master and its slave-side benches.
package i2c_pkg;

    // Master sequencing states.
    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WR_ACK,
        READ,
        MST_NACK,
        STOP
    } i2c_state_e;

    // Quarter-phases within one bit slot.
    typedef enum logic [1:0] {
        PH0,
        PH1,
        PH2,
        PH3
    } qphase_e;

    // Address the reference slave answers to.
    localparam logic [6:0] SLAVE_ADDR = 7'b0101010;

endpackage

// File: rtl/i2c_master_if.sv
// Host handshake plus open-drain bus controls of the I2C master.
interface i2c_master_if #(
    parameter int ADDR_W = 7
);
    logic              start_req;
    logic              rw;
    logic [ADDR_W-1:0] slave_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic              ack_error;
    logic [7:0]        rd_data;
    logic              i2c_scl_oe;
    logic              i2c_sda_oe;
    logic              i2c_sda_in;

    // Master view: the controller itself.
    modport master (
        input  start_req, rw, slave_addr, wr_data, i2c_sda_in,
        output busy, done, ack_error, rd_data, i2c_scl_oe, i2c_sda_oe
    );

    // Slave view: the host issuing requests and resolving the bus.
    modport slave (
        output start_req, rw, slave_addr, wr_data, i2c_sda_in,
        input  busy, done, ack_error, rd_data, i2c_scl_oe, i2c_sda_oe
    );
endinterface

// File: rtl/i2c_phase_gen.sv
// Quarter-phase timebase: QDIV clocks per phase, four phases per bit slot.
module i2c_phase_gen #(
    parameter int QDIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    output logic [1:0] phase,
    output logic       phase_last
);
    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(QDIV - 1);

    logic [CW-1:0] cnt;

    assign phase_last = (cnt == '0);

    // Down-counter per phase; terminal count advances the phase, load restarts at ph0.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt   <= CNT_TOP;
            phase <= 2'd0;
        end else if (phase_last) begin
            cnt   <= CNT_TOP;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, one data byte, ACK handling, STOP.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | lines released, waiting for start_req
//  START    | SDA falls while SCL is high
//  ADDR     | 8 slots: address MSB first, then R/W
//  ADDR_ACK | SDA released, slave ACK sampled
//  WRITE    | 8 slots of the captured write byte
//  WR_ACK   | SDA released, slave ACK of the data byte sampled
//  READ     | 8 slots, SDA released, bits shifted in MSB first
//  MST_NACK | SDA released: master NACKs the single read byte
//  STOP     | SDA rises while SCL is high, then done
module i2c_master
    import i2c_pkg::*;
#(
    parameter int QDIV   = 4,
    parameter int ADDR_W = 7
) (
    input logic         clk,
    input logic         reset,
    i2c_master_if.master bus
);
    localparam logic [3:0] S_IDLE     = 4'(IDLE);
    localparam logic [3:0] S_START    = 4'(START);
    localparam logic [3:0] S_ADDR     = 4'(ADDR);
    localparam logic [3:0] S_ADDR_ACK = 4'(ADDR_ACK);
    localparam logic [3:0] S_WRITE    = 4'(WRITE);
    localparam logic [3:0] S_WR_ACK   = 4'(WR_ACK);
    localparam logic [3:0] S_READ     = 4'(READ);
    localparam logic [3:0] S_MST_NACK = 4'(MST_NACK);
    localparam logic [3:0] S_STOP     = 4'(STOP);

    logic [3:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] sr;
    logic [7:0] wr_q;
    logic       rw_q;
    logic [1:0] sda_sync;
    logic       sda_s;
    logic [1:0] phase;
    logic       phase_last;
    logic       slot_last;
    logic       accept;
    logic       scl_nx;
    logic       sda_nx;

    // A request landing in the done cycle is dropped; the host retries next cycle.
    assign accept    = (state == S_IDLE) && bus.start_req && !bus.done;
    assign slot_last = phase_last && (phase == PH3);
    assign sda_s     = sda_sync[1];

    i2c_phase_gen #(.QDIV(QDIV)) u_phase (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .phase      (phase),
        .phase_last (phase_last)
    );

    // Two-flop synchronizer on the resolved SDA level; idles released.
    always_ff @(posedge clk) begin
        if (reset) sda_sync <= 2'b11;
        else       sda_sync <= {sda_sync[0], bus.i2c_sda_in};
    end

    // Transaction sequencing, bit counting, shift register and host outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            bit_cnt       <= 3'd0;
            sr            <= 8'd0;
            wr_q          <= 8'd0;
            rw_q          <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.ack_error <= 1'b0;
            bus.rd_data   <= 8'd0;
        end else begin
            bus.done <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    // The address frame is one byte, so ADDR_W is expected to be 7.
                    sr            <= 8'({bus.slave_addr, bus.rw});
                    wr_q          <= bus.wr_data;
                    rw_q          <= bus.rw;
                    bus.ack_error <= 1'b0;
                    bus.busy      <= 1'b1;
                    bit_cnt       <= 3'd0;
                    state         <= S_START;
                end
            end else if (slot_last) begin
                case (state)
                    S_START: state <= S_ADDR;
                    S_ADDR: begin
                        sr      <= {sr[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_ADDR_ACK;
                    end
                    S_ADDR_ACK: begin
                        if (sda_s) begin
                            bus.ack_error <= 1'b1;
                            state         <= S_STOP;
                        end else if (rw_q) begin
                            state <= S_READ;
                        end else begin
                            sr    <= wr_q;
                            state <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        sr      <= {sr[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_WR_ACK;
                    end
                    S_WR_ACK: begin
                        if (sda_s) bus.ack_error <= 1'b1;
                        state <= S_STOP;
                    end
                    S_READ: begin
                        sr      <= {sr[6:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_MST_NACK;
                    end
                    S_MST_NACK: state <= S_STOP;
                    S_STOP: begin
                        // A NACKed read never shifted in data, so rd_data keeps its value.
                        if (rw_q && !bus.ack_error) bus.rd_data <= sr;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Line drive decoded from state and quarter-phase: SCL low in ph0/ph1 of bit slots.
    always_comb begin
        scl_nx = 1'b0;
        sda_nx = 1'b0;
        case (state)
            S_START: sda_nx = phase[1];
            S_ADDR, S_WRITE: begin
                scl_nx = ~phase[1];
                sda_nx = ~sr[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_READ, S_MST_NACK: scl_nx = ~phase[1];
            S_STOP: begin
                scl_nx = (phase == PH0);
                sda_nx = (phase == PH0) || (phase == PH1);
            end
            default: ;
        endcase
    end

    // Registered open-drain enables so the pads never see decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.i2c_scl_oe <= 1'b0;
            bus.i2c_sda_oe <= 1'b0;
        end else begin
            bus.i2c_scl_oe <= scl_nx;
            bus.i2c_sda_oe <= sda_nx;
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master with a behavioural I2C slave on the bus.
module tb_i2c_master;
    import i2c_pkg::*;

    localparam int QDIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    i2c_master_if #(.ADDR_W(7)) bus ();

    i2c_master #(.QDIV(QDIV), .ADDR_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND with the pull-up: the line is high unless someone pulls.
    logic slv_oe = 1'b0;
    wire  sda_line = ~(bus.i2c_sda_oe | slv_oe);
    wire  scl_line = ~bus.i2c_scl_oe;
    assign bus.i2c_sda_in = sda_line;

    // Slave behaviour knobs and bus observation.
    logic [7:0] slv_rd_byte  = 8'h00;
    logic       slv_data_ack = 1'b1;
    bit         rise_q[$];
    int         n_start = 0;
    int         n_stop  = 0;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic [7:0] model_rd = 8'h00;

    // What the slave pulls for the upcoming bit, given how many SCL rises it has seen.
    function automatic logic slave_drive(input int i);
        logic [6:0] a;
        logic       r;
        if (i < 8) return 1'b0;
        for (int k = 0; k < 7; k++) a[6-k] = rise_q[k];
        r = rise_q[7];
        if (a != SLAVE_ADDR) return 1'b0;
        if (i == 8) return 1'b1;
        if (r && i >= 9 && i <= 16) return ~slv_rd_byte[3'(16 - i)];
        if (!r && i == 17) return slv_data_ack;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (scl_prev && scl_line && sda_prev && !sda_line) begin
            n_start = n_start + 1;
            rise_q.delete();
            slv_oe <= 1'b0;
        end else if (scl_prev && scl_line && !sda_prev && sda_line) begin
            n_stop = n_stop + 1;
            slv_oe <= 1'b0;
        end
        if (!scl_prev && scl_line) rise_q.push_back(sda_line);
        if (scl_prev && !scl_line) slv_oe <= slave_drive(rise_q.size());
        scl_prev = scl_line;
        sda_prev = sda_line;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: SDA level seen at every SCL rise of a whole transaction.
    function automatic void exp_bits(input logic r, input logic [6:0] a, input logic [7:0] wd,
                                     input logic [7:0] rb, input logic dack,
                                     output logic [31:0] v, output int len);
        bit q[$];
        logic m;
        m = (a == SLAVE_ADDR);
        for (int k = 6; k >= 0; k--) q.push_back(a[k]);
        q.push_back(r);
        q.push_back(!m);
        if (m) begin
            for (int k = 7; k >= 0; k--) q.push_back(r ? rb[k] : wd[k]);
            q.push_back(r ? 1'b1 : !dack);
        end
        q.push_back(1'b0);
        v = 32'd0;
        foreach (q[k]) v = {v[30:0], q[k]};
        len = q.size();
    endfunction

    task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] wd,
                           input logic [7:0] rb, input logic dack,
                           input logic exp_err, input logic [7:0] exp_rd, input int exp_lat,
                           input int dup_at, input bit req_at_done);
        int n, s0, p0, len_e;
        bit got, quiet;
        logic [31:0] v_e, v_o;
        slv_rd_byte  = rb;
        slv_data_ack = dack;
        s0 = n_start;
        p0 = n_stop;
        @(negedge clk);
        bus.start_req = 1'b1;
        bus.rw = r;
        bus.slave_addr = a;
        bus.wr_data = wd;
        @(posedge clk);
        n = 0;
        got = 1'b0;
        while (!got && n < 4000) begin
            @(negedge clk);
            if (n == 0) check("busy_after_accept", 32'(bus.busy), 32'd1);
            bus.start_req = (n == dup_at);
            if (n == dup_at) begin
                bus.rw = ~r;
                bus.slave_addr = 7'h15;
                bus.wr_data = ~wd;
            end
            if (bus.done) got = 1'b1;
            else n++;
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(exp_lat));
        check("ack_error", 32'(bus.ack_error), 32'(exp_err));
        check("rd_data", 32'(bus.rd_data), 32'(exp_rd));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("start_count", 32'(n_start - s0), 32'd1);
        check("stop_count", 32'(n_stop - p0), 32'd1);
        exp_bits(r, a, wd, rb, dack, v_e, len_e);
        v_o = 32'd0;
        foreach (rise_q[k]) v_o = {v_o[30:0], rise_q[k]};
        check("bit_count", 32'(rise_q.size()), 32'(len_e));
        check("bit_stream", v_o, v_e);
        bus.start_req = req_at_done;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            bus.start_req = 1'b0;
            if (bus.busy || bus.done || bus.i2c_scl_oe || bus.i2c_sda_oe) quiet = 1'b0;
        end
        check("idle_after_done", 32'(quiet), 32'd1);
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wd;
        logic [7:0] rb;
        logic       dack;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic r, dk, m, e_err;
        logic [6:0] a;
        logic [7:0] wd, rb, e_rd;
        int e_lat;
        bit quiet;

        vecs[0] = '{1'b0, 7'h2A, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 320};
        vecs[1] = '{1'b1, 7'h2A, 8'h00, 8'hCC, 1'b1, 1'b0, 8'hCC, 320};
        vecs[2] = '{1'b0, 7'h15, 8'h5A, 8'h00, 1'b1, 1'b1, 8'hCC, 176};
        vecs[3] = '{1'b0, 7'h2A, 8'h3C, 8'h00, 1'b0, 1'b1, 8'hCC, 320};
        vecs[4] = '{1'b1, 7'h15, 8'h00, 8'h77, 1'b1, 1'b1, 8'hCC, 176};
        vecs[5] = '{1'b1, 7'h2A, 8'h00, 8'h01, 1'b1, 1'b0, 8'h01, 320};

        bus.start_req = 1'b0;
        bus.rw = 1'b0;
        bus.slave_addr = 7'h00;
        bus.wr_data = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_ack_error", 32'(bus.ack_error), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_scl_oe", 32'(bus.i2c_scl_oe), 32'd0);
        check("rst_sda_oe", 32'(bus.i2c_sda_oe), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        foreach (vecs[i]) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wd, vecs[i].rb, vecs[i].dack,
                    vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_lat, -1, 1'b0);
            model_rd = vecs[i].exp_rd;
        end

        for (int i = 0; i < 8; i++) begin
            r  = 1'($urandom_range(0, 1));
            dk = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) != 0) ? SLAVE_ADDR : 7'($urandom);
            wd = 8'($urandom);
            rb = 8'($urandom);
            m  = (a == SLAVE_ADDR);
            e_err = !m || (!r && !dk);
            e_lat = m ? 80 * QDIV : 44 * QDIV;
            e_rd  = (r && m) ? rb : model_rd;
            model_rd = e_rd;
            run_txn(r, a, wd, rb, dk, e_err, e_rd, e_lat, -1, 1'b0);
        end

        // Request mid-transaction and in the done cycle: both must be dropped.
        run_txn(1'b0, SLAVE_ADDR, 8'h5A, 8'h00, 1'b1, 1'b0, model_rd, 320, 50, 1'b1);

        // Reset during address bit 3 abandons the transfer without a done.
        @(negedge clk);
        bus.start_req = 1'b1;
        bus.rw = 1'b0;
        bus.slave_addr = SLAVE_ADDR;
        bus.wr_data = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        bus.start_req = 1'b0;
        repeat (65) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_scl_oe", 32'(bus.i2c_scl_oe), 32'd0);
        check("midrst_sda_oe", 32'(bus.i2c_sda_oe), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_rd = 8'h00;
        quiet = 1'b1;
        repeat (400) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.i2c_scl_oe || bus.i2c_sda_oe) quiet = 1'b0;
        end
        check("midrst_no_done", 32'(quiet), 32'd1);
        check("midrst_rd_data", 32'(bus.rd_data), 32'd0);
        run_txn(1'b0, SLAVE_ADDR, 8'hA5, 8'h00, 1'b1, 1'b0, 8'h00, 320, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C bus master that drives the slave stage directly downstream: generates SCL, START/STOP, the 7-bit address + R/W, one data byte, and ACK/NACK handling.
- Host side is a start/done handshake.
- Bus side is open-drain: the block only ever pulls lines low or releases them; the pull-up is external (bench: pullup).
- Runs on the system clock; SCL is derived by division. No clock stretching, no arbitration, no repeated START.

Parameters:
QDIV, 4, system clocks per SCL quarter-phase (minimum 3); SCL period = 4*QDIV clocks.
ADDR_W, 7, slave address width.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
start_req  in  1  one-cycle request; accepted only when busy=0.
rw  in  1  0 = write byte to slave, 1 = read byte from slave; captured with start_req.
slave_addr  in  ADDR_W  target address, captured with start_req.
wr_data  in  8  byte to write, captured with start_req.
busy  out  1  high from the cycle after acceptance until done.
done  out  1  one-cycle pulse when the STOP condition completes.
ack_error  out  1  set if the slave NACKs the address or the write byte; valid with done, held until next accept.
rd_data  out  8  byte read from the slave; valid with done when rw=1.
i2c_scl_oe  out  1  1 = pull SCL low, 0 = release.
i2c_sda_oe  out  1  1 = pull SDA low, 0 = release.
i2c_sda_in  in  1  resolved SDA line level.

Behaviour:
- Reset (synchronous, has priority over everything, including mid-transaction): busy=0, done=0, ack_error=0, rd_data=0, both oe=0 (lines released), state IDLE, phase counter 0. No STOP is emitted on reset.
- i2c_sda_in passes through a 2-flop synchronizer; all samples use the synchronized value.
- Timing is built from slots of 4 quarter-phases (ph0..ph3), each QDIV clocks long.
- Bit slot:
  - ph0/ph1: SCL low. SDA updated at ph0 entry: oe=~bit when driving, 0 when receiving.
  - ph2/ph3: SCL released.
  - Sample SDA on the last clock of ph3.
- States and transitions:
  - IDLE: lines released. On start_req, capture {slave_addr, rw, wr_data}, clear ack_error, go to START.
  - START slot: ph0/ph1 SCL and SDA released; ph2/ph3 SDA pulled low with SCL high. Then go to ADDR.
  - ADDR: 8 bit slots, MSB first: addr[6:0] then rw.
  - ADDR_ACK: 1 slot, SDA released. Sample 0 = ACK, go to WRITE (rw=0) or READ (rw=1). Sample 1 = NACK, set ack_error, go to STOP.
  - WRITE: 8 bit slots of wr_data, MSB first, then WR_ACK: 1 slot; a sampled 1 sets ack_error. Then go to STOP.
  - READ: 8 slots, SDA released, shift sampled bits MSB first into the shift register. Then MST_NACK: 1 slot with SDA released (master NACK). Then go to STOP.
  - STOP slot: ph0 SCL low, SDA low; ph1 SCL released, SDA low; ph2/ph3 both released. At the end of ph3: done=1 for one clock, busy=0, rd_data updated (read only), return to IDLE.
- Latency from the accept cycle to done:
  - Full transaction: 20 slots = 80*QDIV clocks (320 at default).
  - Address NACK: 11 slots = 44*QDIV clocks (176 at default).
- start_req while busy=1 is ignored; no queueing.
- start_req in the same cycle as done is ignored. The host must issue it from the next cycle.
- Between transactions SCL idles released (high).

Decomposition:
- Package i2c_pkg holds the state enum (IDLE, START, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, MST_NACK, STOP), the quarter-phase enum, and the shared address localparam (7'b0101010), so slave and master benches agree.
- One sub-module, i2c_phase_gen: counts QDIV clocks, emits a phase index and a phase_last strobe, and restarts on load.
- The master FSM plus the 3-bit bit counter live in i2c_master.

Test Plan:
- Write: addr 0x2A, rw=0, wr_data 0xA5, slave model ACKs -> SDA bytes 0x54 then 0xA5 observed at SCL rising edges; done at accept+320 clocks; ack_error=0.
- Read: addr 0x2A, rw=1, slave returns 0xCC -> rd_data=0xCC at done; SDA released on the 9th data clock (NACK); STOP observed.
- Address NACK: addr 0x15, no slave responds -> ack_error=1, no data slots, STOP emitted, done at accept+176 clocks.
- Write-byte NACK: slave ACKs the address and NACKs the data -> ack_error=1 with done at 320 clocks.
- Second start_req pulsed 50 clocks into a transaction -> ignored; exactly one START and one done observed.
- reset asserted during ADDR bit 3 -> next clock both oe=0, busy=0, done never pulses; a fresh start_req afterwards completes normally.
